conversor_bcd_seq: RTL
======================

# conversor_bcd_seq

Sequential binary-to-decimal converter that produces the four least-significant decimal digits of an unsigned binary word, using a shift-and-add-3 (double-dabble) sequencer. It replaces the combinational `%`/`/` digit extraction on the CPU display path, which was slowing synthesis. It sits between the CPU result register and the 7-segment decoders. A start/busy/done handshake lets the CPU-side logic request a new conversion whenever the displayed value changes.

## Interface
- `LARGURA`, 32: width of the binary input, in bits; must be ≥ 1.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `iniciar` in 1: conversion request, sampled only in state OCIOSO.
- `entrada` in LARGURA: unsigned value to convert; captured on the accepted `iniciar` cycle.
- `ocupado` out 1: high whenever the state is not OCIOSO.
- `pronto` out 1: one-cycle pulse; the digit outputs were updated this cycle.
- `saida1` out 4: units digit (BCD).
- `saida2` out 4: tens digit.
- `saida3` out 4: hundreds digit.
- `saida4` out 4: thousands digit.

## Operation
- Internal state:
  - `bin`: LARGURA-bit shift register.
  - `bcd`: 16-bit working register, four nibbles.
  - `cont`: iteration counter, ⌈log2(LARGURA+1)⌉ bits.
  - `res`: 16-bit result register; drives `saida1..4`.
- FSM states: OCIOSO → CONVERTE → FIM → OCIOSO.
- OCIOSO:
  - If `iniciar`=1: `bin`←`entrada`, `bcd`←0, `cont`←LARGURA, go to CONVERTE.
  - Otherwise hold.
- CONVERTE, one iteration per cycle:
  1. Add 3 to each `bcd` nibble whose value is ≥ 5.
  2. Shift {`bcd`,`bin`} left by 1. The bit shifted out of `bcd[15]` is discarded.
  3. Decrement `cont`.
  4. When `cont` reaches 1 on this cycle, the next state is FIM.
- Truncating `bcd` to 16 bits gives exactly `entrada` mod 10000; higher decimal digits are dropped by design.
- FIM: `res`←`bcd`, `pronto`=1, go to OCIOSO.
- `iniciar` is ignored in CONVERTE and FIM. It is not queued.
- Changes on `entrada` after capture have no effect on the running conversion.
- `res` holds its value between conversions. Outputs never show intermediate `bcd` values.
- Digit mapping: `saida1`=`res[3:0]`, `saida2`=`res[7:4]`, `saida3`=`res[11:8]`, `saida4`=`res[15:12]`.

## Timing
- Reset values:
  - state = OCIOSO.
  - `ocupado`=0, `pronto`=0.
  - `saida1..4`=0.
  - `bin`, `bcd`, `cont` = 0.
- Reset asserted mid-conversion aborts the conversion. The outputs return to their reset values on the next edge, and no `pronto` is produced.
- Reset has priority over `iniciar` in the same cycle.
- `iniciar` accepted at edge t:
  - CONVERTE occupies edges t+1 … t+LARGURA.
  - FIM follows at t+LARGURA+1, when `res` updates and `pronto`=1.
  - Back in OCIOSO after t+LARGURA+2.
- Latency is LARGURA+1 cycles from acceptance to `pronto`; 33 cycles for the default.
- A new `iniciar` is accepted at the earliest on the cycle after `pronto`. Back-to-back throughput is one conversion per LARGURA+2 cycles.
- `ocupado` rises the cycle after acceptance and falls together with `pronto`.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `conversor_pkg`:
  - state encoding (OCIOSO, CONVERTE, FIM);
  - default LARGURA;
  - constant NUM_DIGITOS = 4.
- One sub-module, `soma3`: combinational 4-bit nibble correction (add 3 if ≥ 5). It is instantiated four times in the CONVERTE datapath.
- The rest (FSM, counter, shift registers, result register) lives in `conversor_bcd_seq`.

## Test plan
- `entrada`=1234 with `iniciar` pulsed → at cycle +33, `pronto`=1 and `saida4..1`=1,2,3,4. `ocupado` is high for 33 cycles.
- `entrada`=0, then 9999, then 10000 as back-to-back requests, each issued right after `pronto` → digits 0000, then 9999, then 0000.
- `entrada`=32'hFFFFFFFF (4294967295) → digits 7,2,9,5 (`saida4`..`saida1`). Also `entrada`=65536 → 5,5,3,6.
- `iniciar` re-pulsed at cycle +10 of a 1234 conversion, with `entrada` changed to 42 → ignored. Result is still 1234 with a single `pronto`; `saida` stays stable between conversions.
- `reset` asserted at cycle +15 of a conversion that follows a completed 5678 → next edge: all outputs 0, state OCIOSO, no `pronto`. A fresh request for 8 then yields 0,0,0,8.
- Random `entrada` sweep (≥1000 values, LARGURA=32 and LARGURA=14) → each result equals `entrada` % 10000 per digit, latency exactly LARGURA+1.

Source files
------------

// File: rtl/conversor_pkg.sv
// rtl/conversor_pkg.sv - shared types and constants for the sequential BCD converter
package conversor_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    FIM      = 2'd2
  } estado_t;

  localparam int LARGURA_PADRAO = 32;
  localparam int NUM_DIGITOS    = 4;

endpackage

// File: rtl/soma3.sv
// rtl/soma3.sv - double-dabble nibble correction: add 3 when the digit is 5 or more
module soma3 (
  input  logic [3:0] nibble,
  output logic [3:0] corrigido
);

  assign corrigido = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/conversor_bcd_seq.sv
// rtl/conversor_bcd_seq.sv - sequential binary to 4-digit BCD converter (shift-and-add-3)
module conversor_bcd_seq
  import conversor_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic [LARGURA-1:0] entrada,
  output logic               ocupado,
  output logic               pronto,
  output logic [3:0]         saida1,
  output logic [3:0]         saida2,
  output logic [3:0]         saida3,
  output logic [3:0]         saida4
);

  localparam int CW = $clog2(LARGURA + 1);

  estado_t            estado;
  logic [LARGURA-1:0] bin;
  logic [15:0]        bcd;
  logic [15:0]        bcd_corr;
  logic [15:0]        res;
  logic [CW-1:0]      cont;
  logic [LARGURA+15:0] desloc;

  for (genvar g = 0; g < NUM_DIGITOS; g++) begin : g_soma3
    soma3 u_soma3 (
      .nibble    (bcd[4*g +: 4]),
      .corrigido (bcd_corr[4*g +: 4])
    );
  end

  // Shifting the combined word keeps LARGURA=1 legal; bcd[15] falls off the top.
  assign desloc = {bcd_corr, bin} << 1;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado  <= OCIOSO;
      bin     <= '0;
      bcd     <= '0;
      cont    <= '0;
      res     <= '0;
      ocupado <= 1'b0;
      pronto  <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (iniciar) begin
            bin     <= entrada;
            bcd     <= '0;
            cont    <= CW'(LARGURA);
            ocupado <= 1'b1;
            estado  <= CONVERTE;
          end
        end
        CONVERTE: begin
          bcd  <= desloc[LARGURA +: 16];
          bin  <= desloc[LARGURA-1:0];
          cont <= cont - 1'b1;
          if (cont == CW'(1)) estado <= FIM;
        end
        FIM: begin
          res     <= bcd;
          pronto  <= 1'b1;
          ocupado <= 1'b0;
          estado  <= OCIOSO;
        end
        default: begin
          ocupado <= 1'b0;
          estado  <= OCIOSO;
        end
      endcase
    end
  end

  assign saida1 = res[3:0];
  assign saida2 = res[7:4];
  assign saida3 = res[11:8];
  assign saida4 = res[15:12];

endmodule
